// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared encodings for the EX-stage ALU execute unit:
//                external alu_op codes, one-hot R-type func codes, the
//                internal operation enum and the execute FSM state enum.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // alu_op field driven by the main control decode
  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_SUB  = 2'b01;
  localparam logic [1:0] ALU_OP_SLT  = 2'b10;
  localparam logic [1:0] ALU_OP_FUNC = 2'b11;

  // One-hot R-type function codes
  localparam logic [5:0] FUNC_ADD = 6'b000001;
  localparam logic [5:0] FUNC_SUB = 6'b000010;
  localparam logic [5:0] FUNC_AND = 6'b000100;
  localparam logic [5:0] FUNC_OR  = 6'b001000;
  localparam logic [5:0] FUNC_SLT = 6'b010000;
  localparam logic [5:0] FUNC_MUL = 6'b100000;

  // Internal operation selected by the decoder
  typedef enum logic [2:0] {
    OP_NOTHING = 3'd0,
    OP_ADD     = 3'd1,
    OP_SUB     = 3'd2,
    OP_AND     = 3'd3,
    OP_OR      = 3'd4,
    OP_SLT     = 3'd5,
    OP_MUL     = 3'd6
  } op_e;

  // Execute FSM states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_exec_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_unit_if
//  Description : Handshake/bus bundle between the EX-stage issue logic and
//                the ALU execute unit.
//  Ports       : in_valid/in_ready, alu_op, func, src_a, src_b  (request)
//                out_valid/out_ready, result, zero, ovf, illegal (response)
//                busy (multiply in progress)
//                master = issuer/consumer side, slave = execute unit side
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [5:0]       func;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ovf;
  logic             illegal;
  logic             busy;

  modport master (
    output in_valid, alu_op, func, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, ovf, illegal, busy
  );

  modport slave (
    input  in_valid, alu_op, func, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, ovf, illegal, busy
  );
endinterface : alu_exec_unit_if
`default_nettype wire

// File: rtl/alu_exec_unit_op_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_decode
//  Description : Combinational decode of alu_op + one-hot func into the
//                internal operation and an illegal-op flag.
//  Ports       : alu_op_i  [1:0]  operation class from control decode
//                func_i    [5:0]  one-hot R-type function
//                op_o             internal operation (OP_NOTHING if illegal)
//                illegal_o        func not a legal one-hot code
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decode
  import alu_pkg::*;
#(
  parameter bit MUL_EN = 1'b1
) (
  input  logic [1:0] alu_op_i,
  input  logic [5:0] func_i,
  output op_e        op_o,
  output logic       illegal_o
);

  always_comb begin
    op_o      = OP_NOTHING;
    illegal_o = 1'b0;
    case (alu_op_i)
      ALU_OP_ADD: op_o = OP_ADD;
      ALU_OP_SUB: op_o = OP_SUB;
      ALU_OP_SLT: op_o = OP_SLT;
      default: begin
        // Only exact one-hot codes are legal; zero and multi-hot fall out.
        case (func_i)
          FUNC_ADD: op_o = OP_ADD;
          FUNC_SUB: op_o = OP_SUB;
          FUNC_AND: op_o = OP_AND;
          FUNC_OR:  op_o = OP_OR;
          FUNC_SLT: op_o = OP_SLT;
          FUNC_MUL: begin
            if (MUL_EN) begin
              op_o = OP_MUL;
            end else begin
              illegal_o = 1'b1;
            end
          end
          default:  illegal_o = 1'b1;
        endcase
      end
    endcase
  end

endmodule : alu_op_decode
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_unit
//  Description : EX-stage ALU: decode + registered single-cycle execute for
//                ADD/SUB/AND/OR/SLT and an iterative shift-add multiply.
//  Ports       : clk   rising-edge clock
//                rst   synchronous active-low reset
//                bus   alu_exec_unit_if.slave (request/response handshake,
//                      result, zero/ovf/illegal flags, busy)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter bit MUL_EN  = 1'b1,
  parameter int MUL_LAT = WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  alu_exec_unit_if.slave  bus
);

  localparam int             CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e           state_q,     state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             zero_q,      zero_d;
  logic             ovf_q,       ovf_d;
  logic             illegal_q,   illegal_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [WIDTH-1:0] mcand_q,     mcand_d;
  logic [WIDTH-1:0] mplier_q,    mplier_d;
  logic [WIDTH-1:0] acc_q,       acc_d;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  op_e  w_op;
  logic w_illegal;

  alu_op_decode #(
    .MUL_EN (MUL_EN)
  ) u_decode (
    .alu_op_i  (bus.alu_op),
    .func_i    (bus.func),
    .op_o      (w_op),
    .illegal_o (w_illegal)
  );

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic w_in_ready;
  logic w_accept;

  // A pending result may drain on the same edge a new op is taken.
  assign w_in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  // --------------------------------------------------------------------------
  // Single-cycle datapath
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_sum;
  logic             w_addsub_ovf;
  logic             w_lt;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_ovf;

  assign w_b_eff      = (w_op == OP_SUB) ? (~bus.src_b + WIDTH'(1)) : bus.src_b;
  assign w_sum        = bus.src_a + w_b_eff;
  // Overflow judged on the effective addend, so SUB uses the negated B sign.
  assign w_addsub_ovf = (bus.src_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != bus.src_a[WIDTH-1]);
  assign w_lt         = $signed(bus.src_a) < $signed(bus.src_b);

  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (w_op)
      OP_ADD,
      OP_SUB: begin
        w_alu_res = w_sum;
        w_alu_ovf = w_addsub_ovf;
      end
      OP_AND:  w_alu_res = bus.src_a & bus.src_b;
      OP_OR:   w_alu_res = bus.src_a | bus.src_b;
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, w_lt};
      default: w_alu_res = '0;   // OP_NOTHING (illegal) forces a zero result
    endcase
  end

  // --------------------------------------------------------------------------
  // Multiply step: add shifted multiplicand when the current multiplier LSB
  // is set. Only the low WIDTH bits are kept, so the accumulator never grows.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_acc_next;

  assign w_acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    illegal_d   = illegal_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;

    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_op == OP_MUL) begin
            // Previous result (if any) is consumed on this edge.
            mcand_d     = bus.src_a;
            mplier_d    = bus.src_b;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            state_d     = ST_MUL;
          end else begin
            result_d    = w_alu_res;
            zero_d      = (w_alu_res == '0);
            ovf_d       = w_alu_ovf;
            illegal_d   = w_illegal;
            out_valid_d = 1'b1;
          end
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
        end
      end

      ST_MUL: begin
        acc_d    = w_acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          result_d    = w_acc_next;
          zero_d      = (w_acc_next == '0);
          ovf_d       = 1'b0;
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      illegal_q   <= illegal_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
  assign bus.illegal   = illegal_q;
  assign bus.busy      = (state_q == ST_MUL);

endmodule : alu_exec_unit
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_exec_unit
//  Description : Self-checking bench for alu_exec_unit: directed scenarios
//                with literal expectations, then randomized traffic checked
//                every cycle against a transaction-level reference model.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [1:0]   alu_op;
  logic [5:0]   func;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(W)) bus  ();
  alu_exec_unit_if #(.WIDTH(W)) bus0 ();

  assign bus.in_valid   = in_valid;
  assign bus.alu_op     = alu_op;
  assign bus.func       = func;
  assign bus.src_a      = src_a;
  assign bus.src_b      = src_b;
  assign bus.out_ready  = out_ready;
  assign bus0.in_valid  = in_valid;
  assign bus0.alu_op    = alu_op;
  assign bus0.func      = func;
  assign bus0.src_a     = src_a;
  assign bus0.src_b     = src_b;
  assign bus0.out_ready = out_ready;

  alu_exec_unit #(.WIDTH(W), .MUL_EN(1'b1), .MUL_LAT(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Same unit built without multiply support; MUL must decode as illegal.
  alu_exec_unit #(.WIDTH(W), .MUL_EN(1'b0), .MUL_LAT(W)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  function automatic void check(input string name, input logic [W-1:0] act,
                                input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // --------------------------------------------------------------------------
  // Reference arithmetic straight from the operation definitions
  // --------------------------------------------------------------------------
  function automatic void calc(input logic [1:0] op, input logic [5:0] f,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               output logic [W-1:0] r, output bit ov,
                               output bit il, output bit ismul);
    int           kind;
    logic [W-1:0] bp;
    logic [63:0]  p;
    r = '0; ov = 1'b0; il = 1'b0; ismul = 1'b0;
    if (op == 2'b00)      kind = 0;
    else if (op == 2'b01) kind = 1;
    else if (op == 2'b10) kind = 4;
    else begin
      case (f)
        6'b000001: kind = 0;
        6'b000010: kind = 1;
        6'b000100: kind = 2;
        6'b001000: kind = 3;
        6'b010000: kind = 4;
        6'b100000: kind = 5;
        default:   kind = 6;
      endcase
    end
    case (kind)
      0: begin bp = b;       r = a + bp; ov = (a[W-1] == bp[W-1]) && (r[W-1] != a[W-1]); end
      1: begin bp = ~b + 1;  r = a + bp; ov = (a[W-1] == bp[W-1]) && (r[W-1] != a[W-1]); end
      2: r = a & b;
      3: r = a | b;
      4: r = ($signed(a) < $signed(b)) ? 1 : 0;
      5: begin p = 64'(a) * 64'(b); r = p[W-1:0]; ismul = 1'b1; end
      default: il = 1'b1;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Transaction-level model: a held result slot plus a remaining-cycles
  // count for an in-flight multiply.
  // --------------------------------------------------------------------------
  bit           m_valid = 0, m_zero = 0, m_ovf = 0, m_ill = 0, m_chk_rst = 0;
  logic [W-1:0] m_res = '0, m_pend = '0;
  int           m_left = 0;
  bit           m_acc, m_ov, m_il, m_mul;
  logic [W-1:0] m_r;

  always @(posedge clk) begin
    m_chk_rst = 1'b0;
    if (rst === 1'b0) begin
      m_valid = 0; m_res = '0; m_zero = 0; m_ovf = 0; m_ill = 0;
      m_left = 0; m_chk_rst = 1'b1;
    end else begin
      m_acc = in_valid && (m_left == 0) && (!m_valid || out_ready);
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_valid = 1; m_res = m_pend; m_zero = (m_pend == '0); m_ovf = 0; m_ill = 0;
        end
      end else if (m_acc) begin
        calc(alu_op, func, src_a, src_b, m_r, m_ov, m_il, m_mul);
        if (m_mul) begin
          m_left = W; m_valid = 0; m_pend = m_r;
        end else begin
          m_valid = 1; m_res = m_r; m_zero = (m_r == '0); m_ovf = m_ov; m_ill = m_il;
        end
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("out_valid", W'(bus.out_valid), W'(m_valid));
      check("in_ready",  W'(bus.in_ready),  W'((m_left == 0) && (!m_valid || out_ready)));
      check("busy",      W'(bus.busy),      W'(m_left > 0));
      if (m_valid || m_chk_rst) begin
        check("result",  bus.result,        m_res);
        check("zero",    W'(bus.zero),      W'(m_zero));
        check("ovf",     W'(bus.ovf),       W'(m_ovf));
        check("illegal", W'(bus.illegal),   W'(m_ill));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed helpers (called at #1 after a rising edge)
  // --------------------------------------------------------------------------
  task automatic issue(input logic [1:0] op, input logic [5:0] f,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    bit got = 0;
    in_valid = 1'b1; alu_op = op; func = f; src_a = a; src_b = b;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin got = 1; break; end
    end
    total++;
    if (!got) begin bad++; $display("FAIL issue_timeout: got no in_ready expected in_ready"); end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_res(output logic [W-1:0] r, output logic z, output logic o,
                          output logic il);
    bit got = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin got = 1; break; end
    end
    total++;
    if (!got) begin bad++; $display("FAIL result_timeout: got no out_valid expected out_valid"); end
    r = bus.result; z = bus.zero; o = bus.ovf; il = bus.illegal;
    @(posedge clk); #1;
  endtask

  logic [W-1:0] r;
  logic         z, o, il;
  int           busy_cnt;
  bit           got_mul;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 2'b00; func = 6'b0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; checking = 1'b1;
    @(negedge clk);
    check("rst_result", bus.result, '0);
    check("rst_valid",  W'(bus.out_valid), '0);
    check("rst_busy",   W'(bus.busy), '0);
    @(posedge clk); #1;

    // ADD overflow
    issue(2'b00, 6'b0, 32'h7FFF_FFFF, 32'h1);
    wait_res(r, z, o, il);
    check("add_ovf_res", r, 32'h8000_0000);
    check("add_ovf_ovf", W'(o), 1);
    check("add_ovf_zero", W'(z), 0);

    // SLT signed, SUB to zero
    issue(2'b11, 6'b010000, 32'hFFFF_FFFF, 32'h0);
    wait_res(r, z, o, il);
    check("slt_res", r, 1);
    issue(2'b11, 6'b000010, 32'd5, 32'd5);
    wait_res(r, z, o, il);
    check("sub_res", r, 0);
    check("sub_zero", W'(z), 1);
    check("sub_ovf", W'(o), 0);

    // Multiply with ignored in_valid pulses; MUL_EN=0 copy flags illegal
    issue(2'b11, 6'b100000, 32'd1234, 32'd5678);
    busy_cnt = 0; got_mul = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (n == 0) begin
        check("nomul_valid",   W'(bus0.out_valid), 1);
        check("nomul_illegal", W'(bus0.illegal), 1);
        check("nomul_result",  bus0.result, 0);
        check("nomul_zero",    W'(bus0.zero), 1);
      end
      if (bus.out_valid) begin got_mul = 1; break; end
      if (bus.busy) busy_cnt++;
      in_valid = (n == 4) || (n == 19);
      alu_op = 2'b00; src_a = 32'd9; src_b = 32'd9;
    end
    in_valid = 1'b0;
    check("mul_done", W'(got_mul), 1);
    check("mul_busy_cycles", W'(busy_cnt), 32);
    check("mul_res", bus.result, 32'd7006652);
    @(posedge clk); #1;

    // Back-to-back ADDs, one per cycle
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; alu_op = 2'b00; src_a = W'(i); src_b = W'(3 * i);
      @(negedge clk);
      check("b2b_ready", W'(bus.in_ready), 1);
      if (i > 0) begin
        check("b2b_valid", W'(bus.out_valid), 1);
        check("b2b_res", bus.result, W'(4 * (i - 1)));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_last", bus.result, 32'd20);
    @(posedge clk); #1;

    // Backpressure: result held, nothing accepted
    issue(2'b00, 6'b0, 32'd100, 32'd23);
    out_ready = 1'b0; in_valid = 1'b1; alu_op = 2'b00; src_a = 32'd7; src_b = 32'd8;
    repeat (3) begin
      @(negedge clk);
      check("hold_valid", W'(bus.out_valid), 1);
      check("hold_ready", W'(bus.in_ready), 0);
      check("hold_res",   bus.result, 32'd123);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_ready", W'(bus.in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("release_res", bus.result, 32'd15);
    @(posedge clk); #1;

    // Illegal func codes
    issue(2'b11, 6'b000011, 32'd44, 32'd55);
    wait_res(r, z, o, il);
    check("ill_mh_res", r, 0); check("ill_mh_flag", W'(il), 1); check("ill_mh_zero", W'(z), 1);
    issue(2'b11, 6'b000000, 32'd44, 32'd55);
    wait_res(r, z, o, il);
    check("ill_0_res", r, 0); check("ill_0_flag", W'(il), 1); check("ill_0_zero", W'(z), 1);

    // Reset in the middle of a multiply
    issue(2'b11, 6'b100000, 32'd99, 32'd77);
    repeat (10) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("abort_busy",   W'(bus.busy), 0);
    check("abort_valid",  W'(bus.out_valid), 0);
    check("abort_result", bus.result, 0);
    @(posedge clk); #1;
    issue(2'b00, 6'b0, 32'd2, 32'd3);
    wait_res(r, z, o, il);
    check("post_abort_add", r, 32'd5);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      logic [5:0] legal [6];
      legal = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000};
      rst       = ($urandom_range(0, 299) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      alu_op    = 2'($urandom_range(0, 3));
      func      = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal[$urandom_range(0, 5)];
      case ($urandom_range(0, 5))
        0:       src_a = 32'h7FFF_FFFF;
        1:       src_a = 32'h8000_0000;
        2:       src_a = 32'hFFFF_FFFF;
        default: src_a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       src_b = 32'h0;
        1:       src_b = 32'h8000_0000;
        2:       src_b = src_a;
        default: src_b = $urandom;
      endcase
      @(posedge clk); #1;
    end
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1 checking = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_alu_exec_unit
`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Parametrised successor to the pipeline's ALU control decode. It merges operation decode with a registered execute stage and adds an iterative multi-cycle multiply. Operands and control enter through a valid/ready handshake. Results leave through a registered valid/ready output with zero, overflow and illegal-op flags. It sits in the EX stage; the hazard unit stalls on in_ready low.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
MUL_EN, 1, 1 = MUL function supported; 0 = MUL decodes as illegal
MUL_LAT, WIDTH, multiply iterations (one shift-add per cycle); must equal WIDTH in this generation

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
in_valid  input  1  operation presented
in_ready  output  1  unit can accept this cycle
alu_op  input  2  00 ADD, 01 SUB, 10 SLT, 11 use func
func  input  6  one-hot R-type: 000001 ADD, 000010 SUB, 000100 AND, 001000 OR, 010000 SLT, 100000 MUL
src_a  input  WIDTH  operand A
src_b  input  WIDTH  operand B
out_valid  output  1  result held
out_ready  input  1  consumer takes result
result  output  WIDTH  registered result
zero  output  1  result == 0
ovf  output  1  signed overflow (ADD/SUB only; else 0)
illegal  output  1  func not one-hot-legal while alu_op==11; result forced 0
busy  output  1  multiply in progress

Behaviour:
- Reset (rst==0 at clk edge): state IDLE; out_valid, result, zero, ovf, illegal, busy all 0; multiply counter 0. Reset mid-multiply aborts it with no output. Reset has priority over every other input.
- Accept: a transfer occurs when in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). A result may be consumed and a new op accepted in the same cycle.
- States: IDLE, MUL.
  - IDLE, accept of a non-MUL op: result, flags and out_valid=1 are registered at the next edge (latency 1); stays IDLE.
  - IDLE, accept of MUL: load multiplicand, multiplier and accumulator; counter=0; busy=1; go to MUL.
  - MUL: one shift-add per cycle. When counter==MUL_LAT-1: write the low WIDTH bits of the product to result, set out_valid=1, busy=0, go to IDLE. Latency from accept to out_valid is MUL_LAT cycles.
- Output hold: while out_valid && !out_ready, result and all flags are stable. out_valid drops on the cycle after the consuming edge unless a new op was accepted on that edge.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH. ovf = sign(a)==sign(b') && sign(res)!=sign(a), where b' is src_b for ADD and ~src_b+1 for SUB.
  - AND/OR are bitwise.
  - SLT is signed: result = {WIDTH-1 zeros, a<b}.
  - MUL is unsigned low half; ovf=0.
  - zero is computed on the final result.
- Illegal (alu_op==11, func not in the legal set, including func==0, multi-hot, or MUL with MUL_EN=0): completes in 1 cycle with result=0, zero=1, illegal=1.
- Simultaneous events: an out_ready consume and an accept on the same edge load the new result with no bubble. in_valid during MUL is ignored (in_ready=0); the operands need not be held.

Decomposition:
- Shared package alu_pkg: ALU_OP codes (2-bit), one-hot FUNC codes including FUNC_MUL, internal 3-bit op enum (NOTHING, ADD, SUB, AND, OR, SLT, MUL), FSM state enum.
- One natural sub-module: alu_op_decode (combinational alu_op+func -> internal op + illegal). alu_exec_unit instantiates it plus the datapath and FSM.

Test Plan:
- WIDTH=32, alu_op=00, a=0x7FFFFFFF, b=1, out_ready=1 -> next cycle out_valid=1, result=0x80000000, ovf=1, zero=0.
- alu_op=11, func=010000 (SLT), a=0xFFFFFFFF, b=0 -> result=1; repeat with func=000010 (SUB), a=b=5 -> result=0, zero=1, ovf=0.
- alu_op=11, func=100000 (MUL), a=1234, b=5678 -> busy=1 and in_ready=0 for 32 cycles; out_valid on cycle 32 with result=7006652. in_valid pulses during MUL are not accepted.
- Back-to-back ADDs with out_ready=1 -> one accept per cycle, no bubbles. Then out_ready=0 for 3 cycles -> in_ready=0, result and flags held, no loss.
- alu_op=11, func=000011 and func=000000 -> result=0, illegal=1, zero=1; with MUL_EN=0, func=100000 also gives illegal=1.
- rst=0 asserted at MUL cycle 10 -> next edge: busy=0, out_valid=0, result=0; the following accepted ADD 2+3 returns result=5.
